// File: rtl/obstacle_spawner_pkg.sv
// Shared game constants, FSM encodings and coordinate types.
// The drawing engine and the LFSR stage import the same definitions.
package obstacle_spawner_pkg;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int COL_PITCH = SCREEN_W / 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_DRAW  = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_CLEAR = 3'd4;

   typedef logic [3:0] col_t;
   typedef logic [9:0] xcoord_t;
   typedef logic [8:0] ycoord_t;

endpackage

// File: rtl/obstacle_spawner_if.sv
// Spawn request / drawing-engine handshake bundle.
// The master side is the environment, the slave side is the spawner.
interface obstacle_spawner_if;
   import obstacle_spawner_pkg::*;

   logic       spawn_req;
   col_t       rand_in;
   logic       draw_done;
   xcoord_t    load_x;
   ycoord_t    load_y;
   logic       draw_start;
   logic       busy;
   logic [7:0] spawn_count;

   modport master (
      output spawn_req, rand_in, draw_done,
      input  load_x, load_y, draw_start, busy, spawn_count
   );

   modport slave (
      input  spawn_req, rand_in, draw_done,
      output load_x, load_y, draw_start, busy, spawn_count
   );

endinterface

// File: rtl/obstacle_spawner_col_to_x.sv
// Column index to pixel x: col*PITCH + OFFSET, purely combinational.
// The default 40-pixel pitch collapses to two shifts and adds.
module obstacle_spawner_col_to_x
   import obstacle_spawner_pkg::*;
#(
   parameter int PITCH  = 40,
   parameter int OFFSET = 4
) (
   input  col_t    col,
   output xcoord_t x
);

   xcoord_t col_w;
   assign col_w = {6'd0, col};

   generate
      if (PITCH == 40) begin : g_shift
         assign x = (col_w << 5) + (col_w << 3) + xcoord_t'(OFFSET);
      end else begin : g_mult
         assign x = xcoord_t'(int'(col) * PITCH + OFFSET);
      end
   endgenerate

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawn controller: samples the LFSR column, drives the draw handshake,
// then drops load_x to zero so the LFSR advances for the next spawn.
module obstacle_spawner #(
   parameter int X_OFFSET    = 4,
   parameter int COL_PITCH   = obstacle_spawner_pkg::COL_PITCH,
   parameter int Y_START     = 0,
   parameter int HOLD_CYCLES = 2
) (
   input logic                clk,
   input logic                reset_n,
   obstacle_spawner_if.slave  bus
);
   import obstacle_spawner_pkg::*;

   logic [2:0] state, state_nxt;
   col_t       col, last_col, col_pick;
   logic [3:0] hold_cnt;
   logic       pending, last_valid;
   logic       start_spawn;
   xcoord_t    col_x, load_x;
   ycoord_t    load_y;
   logic       draw_start, busy;
   logic [7:0] spawn_count;

   assign bus.load_x      = load_x;
   assign bus.load_y      = load_y;
   assign bus.draw_start  = draw_start;
   assign bus.busy        = busy;
   assign bus.spawn_count = spawn_count;

   assign start_spawn = (state == ST_IDLE) && (bus.spawn_req || pending);

   // Never repeat the previous column back to back.
   assign col_pick = (last_valid && bus.rand_in == last_col) ? col_t'(bus.rand_in + 4'd1)
                                                             : bus.rand_in;

   obstacle_spawner_col_to_x #(
      .PITCH  (COL_PITCH),
      .OFFSET (X_OFFSET)
   ) u_col_to_x (
      .col (col),
      .x   (col_x)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_spawn) state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_DRAW;
         ST_DRAW:  if (!draw_start && bus.draw_done) state_nxt = ST_HOLD;
         ST_HOLD:  if (hold_cnt == 4'd0) state_nxt = ST_CLEAR;
         ST_CLEAR: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         col         <= '0;
         last_col    <= '0;
         last_valid  <= 1'b0;
         pending     <= 1'b0;
         hold_cnt    <= '0;
         load_x      <= '0;
         load_y      <= '0;
         draw_start  <= 1'b0;
         busy        <= 1'b0;
         spawn_count <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != ST_IDLE);

         // A request in IDLE is consumed directly; only one can queue behind a spawn.
         if (state == ST_IDLE)
            pending <= 1'b0;
         else if (bus.spawn_req)
            pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (start_spawn) col <= col_pick;
            end
            ST_LOAD: begin
               load_x     <= col_x;
               load_y     <= ycoord_t'(Y_START);
               draw_start <= 1'b1;
            end
            ST_DRAW: begin
               draw_start <= 1'b0;
               if (state_nxt == ST_HOLD) hold_cnt <= 4'(HOLD_CYCLES - 1);
            end
            ST_HOLD: begin
               if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
            end
            ST_CLEAR: begin
               load_x     <= '0;
               load_y     <= '0;
               last_col   <= col;
               last_valid <= 1'b1;
               if (spawn_count != 8'hFF) spawn_count <= spawn_count + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: directed cases plus random traffic, each cycle
// compared against a spawn-age reference model.
module tb_obstacle_spawner;

   localparam int H      = 2;
   localparam int PITCH  = 40;
   localparam int OFFSET = 4;
   localparam int YS     = 0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   obstacle_spawner_if bus ();

   obstacle_spawner #(
      .X_OFFSET    (OFFSET),
      .COL_PITCH   (PITCH),
      .Y_START     (YS),
      .HOLD_CYCLES (H)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a spawn is tracked by its age in cycles since acceptance.
   bit m_active, m_pending, m_last_valid;
   int m_age, m_done_age, m_col, m_last, m_count, m_spawns;
   int edges = 0;
   int prev_x = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_pending = 0; m_last_valid = 0;
      m_age = 0; m_done_age = -1; m_col = 0; m_last = 0; m_count = 0;
      prev_x = 0;
   endtask

   task automatic model_step(input bit req, input int rnd, input bit done);
      if (m_active) begin
         if (req) m_pending = 1;
         if (m_done_age < 0 && m_age >= 2 && done) m_done_age = m_age + 1;
         m_age++;
         if (m_done_age >= 0 && m_age > m_done_age + H) begin
            m_active = 0;
            if (m_count < 255) m_count++;
            m_last = m_col;
            m_last_valid = 1;
         end
      end else if (req || m_pending) begin
         m_pending = 0;
         m_col = (m_last_valid && rnd == m_last) ? (rnd + 1) % 16 : rnd;
         m_active = 1;
         m_age = 0;
         m_done_age = -1;
         m_spawns++;
      end
   endtask

   task automatic check_all();
      int ex;
      ex = (m_active && m_age >= 1) ? m_col * PITCH + OFFSET : 0;
      chk("load_x", 32'(bus.load_x), 32'(ex));
      chk("load_y", 32'(bus.load_y), (ex != 0) ? 32'(YS) : 32'd0);
      chk("draw_start", 32'(bus.draw_start), 32'(m_active && m_age == 1));
      chk("busy", 32'(bus.busy), 32'(m_active));
      chk("spawn_count", 32'(bus.spawn_count), 32'(m_count));
      if (prev_x == 0 && bus.load_x != 0) edges++;
      prev_x = int'(bus.load_x);
   endtask

   // Called at a falling edge; returns at the next falling edge after checking.
   task automatic cycle(input bit req, input int rnd, input bit done);
      bus.spawn_req = req;
      bus.rand_in   = 4'(rnd);
      bus.draw_done = done;
      @(posedge clk);
      model_step(req, rnd, done);
      @(negedge clk);
      check_all();
   endtask

   task automatic spawn(input int rnd, input int exp_x);
      cycle(1, rnd, 0);
      cycle(0, 0, 0);
      chk("spawn_x", 32'(bus.load_x), 32'(exp_x));
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      repeat (H + 1) cycle(0, 0, 0);
      chk("spawn_idle", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int c0, e0;
      bus.spawn_req = 0; bus.rand_in = 0; bus.draw_done = 0;
      model_reset();
      m_spawns = 0;
      #12;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;

      // Reset in the middle of DRAW with column 3.
      cycle(1, 3, 0);
      cycle(0, 0, 0);
      chk("mid_x", 32'(bus.load_x), 32'd124);
      cycle(0, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_x", 32'(bus.load_x), 32'd0);
      chk("rst_start", 32'(bus.draw_start), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_count", 32'(bus.spawn_count), 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cycle(0, 0, 0);

      // Column 0 with draw_done three cycles after the request.
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      chk("c0_x", 32'(bus.load_x), 32'd4);
      chk("c0_start", 32'(bus.draw_start), 32'd1);
      cycle(0, 0, 0);
      chk("c0_start_off", 32'(bus.draw_start), 32'd0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("c0_clear_x", 32'(bus.load_x), 32'd4);
      cycle(0, 0, 0);
      chk("c0_zero_x", 32'(bus.load_x), 32'd0);
      chk("c0_count", 32'(bus.spawn_count), 32'd1);

      // Column 15, then 15 again wraps to column 0.
      spawn(15, 604);
      spawn(15, 4);

      // Requests during DRAW and HOLD: one queues, the other is dropped.
      c0 = m_count;
      e0 = edges;
      cycle(1, 5, 0);
      cycle(0, 0, 0);
      cycle(1, 0, 0);
      cycle(0, 0, 1);
      cycle(1, 0, 0);
      repeat (30) cycle(0, 9, 1);
      chk("pend_count", 32'(bus.spawn_count), 32'(c0 + 2));
      chk("pend_edges", 32'(edges - e0), 32'd2);

      // draw_done coincident with draw_start is ignored.
      cycle(1, 7, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("coinc_x", 32'(bus.load_x), 32'd284);
      cycle(0, 0, 0);
      chk("coinc_zero", 32'(bus.load_x), 32'd0);

      // Random traffic.
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(3) == 0, int'($urandom_range(15)), $urandom_range(2) == 0);

      // Back-to-back spawns up to saturation.
      e0 = edges;
      for (int i = 0; i < 2200; i++)
         cycle(1, int'($urandom_range(15)), 1);
      chk("sat_count", 32'(bus.spawn_count), 32'd255);
      chk("sat_edges", 32'(edges - e0 >= 300), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Spawn controller that sits directly downstream of the 4-bit LFSR random-integer generator. On each spawn request it samples the random column (0-15) and converts it to a nonzero pixel x-coordinate. It hands that coordinate to the drawing engine with a start/done handshake, then returns `load_x` to zero. The 0-to-nonzero transition on `load_x` is what advances the LFSR, so every completed spawn yields a fresh random value for the next one.

## Interface
- `X_OFFSET`, 4: pixel offset added to every x. Must be ≥1 so column 0 still produces nonzero `load_x`.
- `COL_PITCH`, 40: pixels per column (640/16).
- `Y_START`, 0: constant spawn y-coordinate driven on `load_y`.
- `HOLD_CYCLES`, 2: cycles `load_x` stays valid after `draw_done`. Legal range 1-15.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spawn_req`  in  1  request pulse. One-deep pending latch when not IDLE.
- `rand_in`  in  4  random column from LFSR.
- `draw_done`  in  1  drawing engine finished; single-cycle pulse.
- `load_x`  out  10  spawn x-coordinate. 0 when no spawn is active.
- `load_y`  out  9  spawn y-coordinate (`Y_START`) while `load_x` ≠ 0, else 0.
- `draw_start`  out  1  one-cycle start pulse to the drawing engine.
- `busy`  out  1  high in every state except IDLE.
- `spawn_count`  out  8  completed spawns, saturating at 255.

## Operation
- FSM states: IDLE, LOAD, DRAW, HOLD, CLEAR.
- **IDLE, with `spawn_req` or pending set:**
  - latch `col` = `rand_in`; if `last_valid` and `rand_in` == `last_col`, then `col` = `rand_in`+1 mod 16 (no immediate repeat);
  - clear pending; go to LOAD.
- **LOAD:**
  - `load_x` <= `col*COL_PITCH + X_OFFSET` (10-bit; max 604 with defaults);
  - `load_y` <= `Y_START`; `draw_start` <= 1; go to DRAW.
- **DRAW:**
  - `draw_start` is high only in the first DRAW cycle, then 0;
  - `draw_done` is ignored while `draw_start` is high;
  - on `draw_done`: load hold counter = `HOLD_CYCLES`-1; go to HOLD.
- **HOLD:** decrement counter; at 0 go to CLEAR.
- **CLEAR:**
  - `load_x` <= 0, `load_y` <= 0;
  - `last_col` <= `col`, `last_valid` <= 1;
  - `spawn_count` += 1, saturating at 255;
  - go to IDLE.
- `spawn_req` in any non-IDLE state sets pending; further requests while pending are dropped.
- `spawn_req` in IDLE takes effect immediately and does not set pending.
- `rand_in` is sampled only on the IDLE→LOAD edge; later changes have no effect on the current spawn.

## Timing
- **Reset (async):**
  - state IDLE, `load_x`=0, `load_y`=0, `draw_start`=0, `busy`=0, `spawn_count`=0;
  - pending=0, `last_valid`=0, `last_col`=0.
- **Reset mid-operation:** all of the above apply immediately; the in-flight spawn is abandoned and is not counted.
- All outputs are registered; no combinational input-to-output path.
- **Latency:** `spawn_req` sampled at edge E0 → `load_x` valid and `draw_start`=1 after E1.
- **Hold/clear:**
  - `load_x` stays valid from E1 through `HOLD_CYCLES` cycles after the edge that samples `draw_done`;
  - it then reads 0 for exactly one CLEAR-exit cycle minimum before any re-assertion.
- **Back-to-back:** with pending set, the minimum spacing between `load_x` rising edges is `HOLD_CYCLES`+5 cycles, assuming `draw_done` in the first eligible cycle.
- **Simultaneous events:**
  - `spawn_req` during CLEAR sets pending, serviced from IDLE next cycle;
  - `draw_done` coincident with `draw_start` is ignored.

## Structure
- Shared `game_pkg` (or `game_defs.vh`) holds `SCREEN_W`=640, `SCREEN_H`=480, `COL_PITCH`, and the FSM state encodings. The drawing engine and the LFSR stage use the same constants.
- One natural sub-module: `col_to_x`, combinational `col*COL_PITCH + X_OFFSET`. With the default pitch this is implementable as `(col<<5)+(col<<3)+X_OFFSET`.

## Test plan
- Reset mid-DRAW (`load_x`=124): assert `reset_n`=0 → all outputs 0 asynchronously, `spawn_count` unchanged at its pre-spawn value, FSM IDLE after release.
- `rand_in`=0, `spawn_req` pulse, `draw_done` 3 cycles later → `load_x`=4, single-cycle `draw_start`, `load_x` back to 0 after 2 HOLD cycles, `spawn_count`=1.
- `rand_in`=15 → `load_x`=604. Next spawn with `rand_in`=15 again → column wraps to 0, `load_x`=4.
- `spawn_req` during DRAW, then again during HOLD → exactly one extra spawn starts after CLEAR, the second request is dropped, and `spawn_count` ends at 2.
- Pulse `draw_done` in the same cycle as `draw_start`, then again 2 cycles later → only the second pulse advances to HOLD.
- 300 back-to-back spawns → `spawn_count` saturates at 255, `load_x` returns to 0 between every spawn, and a 0→nonzero edge is observed each time.
